// File: rtl/noc_route_pkg.sv
// Shared definitions for the NoC route input stage.
// Direction indices, FSM state type and field-width helper.
package noc_route_pkg;

   localparam int LOCAL = 0;
   localparam int EAST  = 1;
   localparam int WEST  = 2;
   localparam int NORTH = 3;
   localparam int SOUTH = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PASS = 1'b1
   } state_t;

   // Coordinate field width; a 1-wide mesh still needs one bit.
   function automatic int field_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream style bundle: TVALID/TREADY/TDATA/TLAST/TID.
// m drives the stream, s consumes it.
interface axis_if #(
   parameter int DATA_WIDTH = 40,
   parameter int ID_WIDTH   = 4
);

   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;
   logic [ID_WIDTH-1:0]   tid;

   modport m (
      output tvalid,
      output tdata,
      output tlast,
      output tid,
      input  tready
   );

   modport s (
      input  tvalid,
      input  tdata,
      input  tlast,
      input  tid,
      output tready
   );

endinterface

// File: rtl/route_compute.sv
// Dimension-ordered route decode: target coords -> one-hot port.
// Define ROUTE_YX_EN to resolve Y before X; default is XY order.
module route_compute
   import noc_route_pkg::*;
#(
   parameter int CHANNEL_NUMBER = 5,
   parameter int XW             = 2,
   parameter int YW             = 2,
   parameter int ROUTER_X       = 0,
   parameter int ROUTER_Y       = 0
) (
   input  logic [XW-1:0]             target_x,
   input  logic [YW-1:0]             target_y,
   output logic [CHANNEL_NUMBER-1:0] selector
);

   localparam logic [XW-1:0] RX = XW'(ROUTER_X);
   localparam logic [YW-1:0] RY = YW'(ROUTER_Y);

   logic x_gt;
   logic x_lt;
   logic y_gt;
   logic y_lt;

   assign x_gt = target_x > RX;
   assign x_lt = target_x < RX;
   assign y_gt = target_y > RY;
   assign y_lt = target_y < RY;

   // Pick exactly one output port; extra channels stay idle.
   always_comb begin
      selector = '0;
`ifdef ROUTE_YX_EN
      if (y_gt)
         selector[NORTH] = 1'b1;
      else if (y_lt)
         selector[SOUTH] = 1'b1;
      else if (x_gt)
         selector[EAST] = 1'b1;
      else if (x_lt)
         selector[WEST] = 1'b1;
      else
         selector[LOCAL] = 1'b1;
`else
      if (x_gt)
         selector[EAST] = 1'b1;
      else if (x_lt)
         selector[WEST] = 1'b1;
      else if (y_gt)
         selector[NORTH] = 1'b1;
      else if (y_lt)
         selector[SOUTH] = 1'b1;
      else
         selector[LOCAL] = 1'b1;
`endif
   end

endmodule

// File: rtl/route_input_stage.sv
// Router ingress: header decode, one-deep output register, strays.
// Optional macro ROUTE_YX_EN selects YX instead of XY routing.
module route_input_stage
   import noc_route_pkg::*;
#(
   parameter int DATA_WIDTH     = 40,
   parameter int ID_WIDTH       = 4,
   parameter int CHANNEL_NUMBER = 5,
   parameter int MAX_ROUTERS_X  = 4,
   parameter int MAX_ROUTERS_Y  = 4,
   parameter int ROUTER_X       = 0,
   parameter int ROUTER_Y       = 0,
   parameter int ROUTING_HEADER = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   axis_if.s                         in,
   axis_if.m                         out,
   output logic [CHANNEL_NUMBER-1:0] selector,
   output logic                      busy,
   output logic [7:0]                drop_count
);

   localparam int XW = field_w(MAX_ROUTERS_X);
   localparam int YW = field_w(MAX_ROUTERS_Y);
   localparam logic [ID_WIDTH-1:0] HDR = ID_WIDTH'(ROUTING_HEADER);

   state_t state;

   logic [XW-1:0] target_x;
   logic [YW-1:0] target_y;
   logic [XW-1:0] hdr_x;
   logic [YW-1:0] hdr_y;
   logic [XW-1:0] route_x;
   logic [YW-1:0] route_y;
   logic [CHANNEL_NUMBER-1:0] route_sel;

   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic [ID_WIDTH-1:0]   out_id;

   logic load_ok;
   logic is_hdr;
   logic in_ready;
   logic in_fire;
   logic hdr_take;
   logic stray;
   logic fwd;
   logic out_done;
   logic keep_route;

   assign load_ok  = !out_valid || out.tready;
   assign is_hdr   = in.tid == HDR;
   assign in_fire  = in.tvalid && in_ready;
   assign hdr_take = in_fire && is_hdr && (state == IDLE);
   assign stray    = in_fire && !is_hdr && (state == IDLE);
   assign fwd      = hdr_take || (in_fire && (state == PASS));
   assign out_done = out_valid && out.tready && out_last;

   // Header field layout: low field is Y, the one above it is X.
   assign hdr_y = YW'(in.tdata[XW-1:0]);
   assign hdr_x = XW'(in.tdata[XW+YW-1:XW]);

   // Route a fresh header, otherwise re-derive from the held target.
   assign route_x = hdr_take ? hdr_x : target_x;
   assign route_y = hdr_take ? hdr_y : target_y;

   // Selector stays up until the packet's last beat leaves.
   assign keep_route = busy && !out_done;

   route_compute #(
      .CHANNEL_NUMBER (CHANNEL_NUMBER),
      .XW             (XW),
      .YW             (YW),
      .ROUTER_X       (ROUTER_X),
      .ROUTER_Y       (ROUTER_Y)
   ) u_route (
      .target_x (route_x),
      .target_y (route_y),
      .selector (route_sel)
   );

   // Strays are swallowed in IDLE; a new header waits out a packet.
   always_comb begin
      in_ready = load_ok;
      unique case (state)
         IDLE: if (!is_hdr) in_ready = 1'b1;
         PASS: if (is_hdr)  in_ready = 1'b0;
      endcase
   end

   // Packet framing: leave PASS once TLAST is taken at ingress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:
               if (hdr_take && !in.tlast)
                  state <= PASS;
            PASS:
               if (in_fire && in.tlast)
                  state <= IDLE;
         endcase
      end
   end

   // One-deep egress register; payload only moves on a load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_id    <= '0;
      end else if (fwd) begin
         out_valid <= 1'b1;
         out_data  <= in.tdata;
         out_last  <= in.tlast;
         out_id    <= in.tid;
      end else if (out.tready) begin
         out_valid <= 1'b0;
      end
   end

   // Latch the destination of each accepted header.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         target_x <= '0;
         target_y <= '0;
      end else if (hdr_take) begin
         target_x <= hdr_x;
         target_y <= hdr_y;
      end
   end

   // Busy/selector span header acceptance to last beat egress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= 1'b0;
         selector <= '0;
      end else if (hdr_take || keep_route) begin
         busy     <= 1'b1;
         selector <= route_sel;
      end else begin
         busy     <= 1'b0;
         selector <= '0;
      end
   end

   // Saturating stray-beat counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         drop_count <= '0;
      else if (stray && (drop_count != 8'hFF))
         drop_count <= drop_count + 8'd1;
   end

   assign in.tready  = in_ready;
   assign out.tvalid = out_valid;
   assign out.tdata  = out_data;
   assign out.tlast  = out_last;
   assign out.tid    = out_id;

endmodule

// File: tb/tb_route_input_stage.sv
// Directed bench for route_input_stage at router (1,1) in a 4x4 mesh.
// Header TDATA: [1:0]=y, [3:2]=x; data beats use TID 1.
module tb_route_input_stage;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] sel;
   logic       busy;
   logic [7:0] dc;
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [4:0] exp_sel;

   axis_if #(.DATA_WIDTH(40), .ID_WIDTH(4)) in_if ();
   axis_if #(.DATA_WIDTH(40), .ID_WIDTH(4)) out_if ();

   route_input_stage #(
      .DATA_WIDTH     (40),
      .ID_WIDTH       (4),
      .CHANNEL_NUMBER (5),
      .MAX_ROUTERS_X  (4),
      .MAX_ROUTERS_Y  (4),
      .ROUTER_X       (1),
      .ROUTER_Y       (1),
      .ROUTING_HEADER (0)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in         (in_if),
      .out        (out_if),
      .selector   (sel),
      .busy       (busy),
      .drop_count (dc)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [39:0] d,
                      input logic l, input logic [3:0] id);
      in_if.tvalid = v;
      in_if.tdata  = d;
      in_if.tlast  = l;
      in_if.tid    = id;
   endtask

   task automatic test_reset();
      n_cmp++; if (out_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid got %b want 0", out_if.tvalid); end
      n_cmp++; if (out_if.tdata !== 40'd0) begin n_bad++; $display("FAIL rst_tdata got %0h want 0", out_if.tdata); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
      n_cmp++; if (sel !== 5'b00000) begin n_bad++; $display("FAIL rst_sel got %b want 00000", sel); end
      n_cmp++; if (dc !== 8'd0) begin n_bad++; $display("FAIL rst_drop got %0d want 0", dc); end
      rst = 1'b0;
   endtask

   task automatic test_route_east();
      drv(1, 40'd13, 0, 4'd0);
      #1;
      n_cmp++; if (in_if.tready !== 1'b1) begin n_bad++; $display("FAIL east_hdr_ready got %b want 1", in_if.tready); end
      step();
      n_cmp++; if (out_if.tvalid !== 1'b1) begin n_bad++; $display("FAIL east_hdr_valid got %b want 1", out_if.tvalid); end
      n_cmp++; if (out_if.tdata !== 40'd13) begin n_bad++; $display("FAIL east_hdr_data got %0d want 13", out_if.tdata); end
      n_cmp++; if (sel !== 5'b00010) begin n_bad++; $display("FAIL east_hdr_sel got %b want 00010", sel); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL east_hdr_busy got %b want 1", busy); end
      for (int i = 0; i < 3; i++) begin
         drv(1, 40'(100 + i), (i == 2), 4'd1);
         step();
         n_cmp++; if (out_if.tdata !== 40'(100 + i)) begin n_bad++; $display("FAIL east_beat%0d_data got %0d want %0d", i, out_if.tdata, 100 + i); end
         n_cmp++; if (out_if.tlast !== (i == 2)) begin n_bad++; $display("FAIL east_beat%0d_last got %b want %b", i, out_if.tlast, (i == 2)); end
         n_cmp++; if (sel !== 5'b00010) begin n_bad++; $display("FAIL east_beat%0d_sel got %b want 00010", i, sel); end
         n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL east_beat%0d_busy got %b want 1", i, busy); end
      end
      drv(0, 40'd0, 0, 4'd0);
      step();
      n_cmp++; if (out_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL east_end_valid got %b want 0", out_if.tvalid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL east_end_busy got %b want 0", busy); end
      n_cmp++; if (sel !== 5'b00000) begin n_bad++; $display("FAIL east_end_sel got %b want 00000", sel); end
   endtask

   task automatic test_single_beat();
      drv(1, 40'd5, 1, 4'd0);
      step();
      n_cmp++; if (out_if.tvalid !== 1'b1) begin n_bad++; $display("FAIL single_valid got %b want 1", out_if.tvalid); end
      n_cmp++; if (out_if.tlast !== 1'b1) begin n_bad++; $display("FAIL single_last got %b want 1", out_if.tlast); end
      n_cmp++; if (sel !== 5'b00001) begin n_bad++; $display("FAIL single_sel got %b want 00001", sel); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy got %b want 1", busy); end
      drv(0, 40'd0, 0, 4'd0);
      step();
      n_cmp++; if (out_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL single_end_valid got %b want 0", out_if.tvalid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_end_busy got %b want 0", busy); end
      n_cmp++; if (sel !== 5'b00000) begin n_bad++; $display("FAIL single_end_sel got %b want 00000", sel); end
   endtask

   task automatic test_drop();
      for (int i = 0; i < 2; i++) begin
         drv(1, 40'd77, 0, 4'd3);
         #1;
         n_cmp++; if (in_if.tready !== 1'b1) begin n_bad++; $display("FAIL drop%0d_ready got %b want 1", i, in_if.tready); end
         step();
         n_cmp++; if (out_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL drop%0d_valid got %b want 0", i, out_if.tvalid); end
      end
      n_cmp++; if (dc !== 8'd2) begin n_bad++; $display("FAIL drop_two got %0d want 2", dc); end
      repeat (298) step();
      n_cmp++; if (dc !== 8'd255) begin n_bad++; $display("FAIL drop_sat got %0d want 255", dc); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy got %b want 0", busy); end
      drv(0, 40'd0, 0, 4'd0);
   endtask

   task automatic test_stall();
`ifdef ROUTE_YX_EN
      exp_sel = 5'b10000;
`else
      exp_sel = 5'b00010;
`endif
      out_if.tready = 1'b0;
      drv(1, 40'd8, 0, 4'd0);
      #1;
      n_cmp++; if (in_if.tready !== 1'b1) begin n_bad++; $display("FAIL stall_hdr_ready got %b want 1", in_if.tready); end
      step();
      n_cmp++; if (sel !== exp_sel) begin n_bad++; $display("FAIL stall_sel got %b want %b", sel, exp_sel); end
      drv(1, 40'd200, 1, 4'd1);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_cmp++; if (in_if.tready !== 1'b0) begin n_bad++; $display("FAIL stall%0d_ready got %b want 0", i, in_if.tready); end
         n_cmp++; if (out_if.tvalid !== 1'b1) begin n_bad++; $display("FAIL stall%0d_valid got %b want 1", i, out_if.tvalid); end
         n_cmp++; if (out_if.tdata !== 40'd8) begin n_bad++; $display("FAIL stall%0d_data got %0d want 8", i, out_if.tdata); end
         step();
      end
      out_if.tready = 1'b1;
      #1;
      n_cmp++; if (in_if.tready !== 1'b1) begin n_bad++; $display("FAIL stall_release_ready got %b want 1", in_if.tready); end
      step();
      n_cmp++; if (out_if.tdata !== 40'd200) begin n_bad++; $display("FAIL stall_beat_data got %0d want 200", out_if.tdata); end
      n_cmp++; if (out_if.tlast !== 1'b1) begin n_bad++; $display("FAIL stall_beat_last got %b want 1", out_if.tlast); end
      n_cmp++; if (sel !== exp_sel) begin n_bad++; $display("FAIL stall_beat_sel got %b want %b", sel, exp_sel); end
      drv(0, 40'd0, 0, 4'd0);
      step();
      n_cmp++; if (out_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL stall_end_valid got %b want 0", out_if.tvalid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stall_end_busy got %b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      drv(1, 40'd13, 0, 4'd0);
      step();
      drv(1, 40'd100, 0, 4'd1);
      step();
      drv(1, 40'd101, 0, 4'd1);
      step();
      #1;
      rst = 1'b1;
      #1;
      n_cmp++; if (out_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got %b want 0", out_if.tvalid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", busy); end
      n_cmp++; if (sel !== 5'b00000) begin n_bad++; $display("FAIL mid_rst_sel got %b want 00000", sel); end
      n_cmp++; if (dc !== 8'd0) begin n_bad++; $display("FAIL mid_rst_drop got %0d want 0", dc); end
      n_cmp++; if (out_if.tdata !== 40'd0) begin n_bad++; $display("FAIL mid_rst_data got %0d want 0", out_if.tdata); end
      drv(0, 40'd0, 0, 4'd0);
      #2;
      rst = 1'b0;
      step();
      drv(1, 40'd5, 1, 4'd0);
      step();
      n_cmp++; if (out_if.tvalid !== 1'b1) begin n_bad++; $display("FAIL mid_next_valid got %b want 1", out_if.tvalid); end
      n_cmp++; if (sel !== 5'b00001) begin n_bad++; $display("FAIL mid_next_sel got %b want 00001", sel); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_next_busy got %b want 1", busy); end
      drv(0, 40'd0, 0, 4'd0);
      step();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_end_busy got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      drv(1, 40'd13, 0, 4'd0);
      step();
      n_cmp++; if (sel !== 5'b00010) begin n_bad++; $display("FAIL b2b_a_sel got %b want 00010", sel); end
      drv(1, 40'd5, 1, 4'd0);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_cmp++; if (in_if.tready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold%0d_ready got %b want 0", i, in_if.tready); end
         step();
      end
      n_cmp++; if (out_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_valid got %b want 0", out_if.tvalid); end
      drv(1, 40'd102, 1, 4'd1);
      #1;
      n_cmp++; if (in_if.tready !== 1'b1) begin n_bad++; $display("FAIL b2b_last_ready got %b want 1", in_if.tready); end
      step();
      n_cmp++; if (out_if.tdata !== 40'd102) begin n_bad++; $display("FAIL b2b_last_data got %0d want 102", out_if.tdata); end
      n_cmp++; if (sel !== 5'b00010) begin n_bad++; $display("FAIL b2b_last_sel got %b want 00010", sel); end
      drv(1, 40'd5, 1, 4'd0);
      #1;
      n_cmp++; if (in_if.tready !== 1'b1) begin n_bad++; $display("FAIL b2b_b_ready got %b want 1", in_if.tready); end
      step();
      n_cmp++; if (out_if.tdata !== 40'd5) begin n_bad++; $display("FAIL b2b_b_data got %0d want 5", out_if.tdata); end
      n_cmp++; if (sel !== 5'b00001) begin n_bad++; $display("FAIL b2b_b_sel got %b want 00001", sel); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_b_busy got %b want 1", busy); end
      drv(0, 40'd0, 0, 4'd0);
      step();
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_end_busy got %b want 0", busy); end
      n_cmp++; if (out_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL b2b_end_valid got %b want 0", out_if.tvalid); end
   endtask

   initial begin
      rst = 1'b1;
      drv(0, 40'd0, 0, 4'd0);
      out_if.tready = 1'b1;
      repeat (2) step();
      test_reset();
      step();
      test_route_east();
      test_single_beat();
      test_drop();
      test_stall();
      test_reset_mid();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/route_input_stage.md
ROUTE_INPUT_STAGE -- requirements
Module: route_input_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 40, width of TDATA.
REQ-002 SHALL have parameter ID_WIDTH, 4, width of TID.
REQ-003 SHALL have parameter CHANNEL_NUMBER, 5, output channel count; minimum 5.
REQ-004 SHALL have parameters MAX_ROUTERS_X / MAX_ROUTERS_Y, 4 / 4, mesh dimensions; X/Y field widths are $clog2 of each.
REQ-005 SHALL have parameters ROUTER_X / ROUTER_Y, 0 / 0, this router's coordinates.
REQ-006 SHALL have parameter ROUTING_HEADER, 0, TID value marking a header beat.
REQ-007 clk  input  1  clock; one clock; all state on rising edge.
REQ-008 rst  input  1  reset; asynchronous, active-high.
REQ-009 in  axis_if.s  --  ingress stream (TVALID, TREADY, TDATA, TLAST, TID).
REQ-010 out  axis_if.m  --  egress stream, same fields, registered.
REQ-011 selector  output  CHANNEL_NUMBER  one-hot output channel for current packet; zero when no packet is routed.
REQ-012 busy  output  1  high from header acceptance until the TLAST beat leaves out.
REQ-013 drop_count  output  8  saturating count of discarded stray beats.

Function
REQ-014 SHALL use states IDLE and PASS.
REQ-015 IDLE: in.TVALID with TID==ROUTING_HEADER and the output register able to load -> accept header, latch target_y=TDATA[Xw-1:0], target_x=TDATA[Xw+Yw-1:Xw], go to PASS.
REQ-016 IDLE: in.TVALID with TID!=ROUTING_HEADER -> in.TREADY=1, beat discarded, drop_count+1, saturating at 255.
REQ-017 PASS: all beats forwarded; a header beat arriving in PASS SHALL stall (in.TREADY=0) until return to IDLE.
REQ-018 PASS -> IDLE SHALL occur on the cycle the TLAST beat is accepted at in; busy and selector SHALL hold until that beat completes at out (out.TVALID&&out.TREADY&&out.TLAST).
REQ-019 Output register one-deep; in.TREADY = !out.TVALID || out.TREADY (except REQ-017); ingress->egress latency exactly 1 cycle; no bubbles at full throughput.
REQ-020 out fields SHALL be stable while out.TVALID && !out.TREADY.
REQ-021 selector SHALL be registered and valid in the same cycle the header first appears on out.TVALID.
REQ-022 Routing (XY): tx>ROUTER_X -> bit1 (east); tx<ROUTER_X -> bit2 (west); else ty>ROUTER_Y -> bit3 (north); ty<ROUTER_Y -> bit4 (south); else bit0 (local). Bits >=5 are always 0.
REQ-023 Single-beat packet (header with TLAST=1) SHALL be routed and forwarded; busy clears after it leaves out.
REQ-024 A header accepted the cycle after the previous TLAST leaves out SHALL NOT be delayed beyond REQ-019 latency.

Reset
REQ-025 rst SHALL force IDLE, out.TVALID=0, out data fields 0, selector=0, busy=0, drop_count=0, targets 0, immediately and asynchronously, including mid-packet; in.TREADY combinational per state after release.

Configuration
REQ-026 Macro ROUTE_YX_EN defined: Y dimension resolved before X (north/south checked first, then east/west, then local).
REQ-027 ROUTE_YX_EN undefined: XY order of REQ-022.

Structure
REQ-028 Package noc_route_pkg SHALL hold direction index constants (LOCAL=0, EAST=1, WEST=2, NORTH=3, SOUTH=4) and the state enum.
REQ-029 Combinational sub-module route_compute SHALL map (target_x, target_y) to one-hot selector; registering stays in route_input_stage.

Verification
REQ-030 ROUTER_X=1,ROUTER_Y=1; header TDATA target x=3,y=1, 3 data beats, last TLAST -> selector=5'b00010 through final beat, busy 0 one cycle after last beat leaves.
REQ-031 Header x=1,y=1 with TLAST=1 -> one output beat, selector=5'b00001 for one cycle, busy pulses one cycle.
REQ-032 Two data beats TID!=header in IDLE -> no out.TVALID, drop_count=2; 300 strays -> drop_count=255.
REQ-033 Header x=2,y=0 with out.TREADY held 0 for 4 cycles -> out beat stable, in.TREADY=0, no loss; XY build selector=east, ROUTE_YX_EN build selector=south.
REQ-034 rst asserted mid-packet after beat 2 -> out.TVALID, busy, selector 0 same cycle; next header routed normally.
REQ-035 Second header presented during PASS -> stalled until first packet's TLAST accepted, then accepted next cycle.
